// File: rtl/toggle_evt_pkg.sv
// Shared types and default constants for the toggle-encoded event receiver.
package toggle_evt_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } evt_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop level synchronizer for a single asynchronous input bit.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the raw level through the chain; the oldest sample is the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ff_q <= {STAGES{1'b0}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receives a toggle-encoded event level, emits one pulse per level change and
// keeps a drainable pending count plus a wrapping total count.
module toggle_event_rx
  import toggle_evt_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tog_in,
  input  logic             clr,
  input  logic             out_ready,
  output logic             evt_pulse,
  output logic             out_valid,
  output logic [CNT_W-1:0] pend_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       SETTLE_RST = 3'(SYNC_STAGES);

  logic             s_lvl;
  evt_state_e       state_q, state_d;
  logic             ref_q, ref_d;
  logic [2:0]       settle_q, settle_d;
  logic             evt_pulse_q, evt_pulse_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             ovf_q, ovf_d;
  logic             evt_s;
  logic             drain_s;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d_i (tog_in),
    .q_o (s_lvl)
  );

  // After reset the chain still holds zeros, so INIT keeps re-capturing the
  // level until the first real sample has reached s_lvl.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    settle_d    = settle_q;
    evt_s       = 1'b0;
    pend_d      = pend_q;
    total_d     = total_q;
    ovf_d       = ovf_q;
    evt_pulse_d = 1'b0;
    drain_s     = valid_q && out_ready;

    case (state_q)
      INIT: begin
        ref_d = s_lvl;
        if (settle_q == 3'd0) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q - 3'd1;
        end
      end
      RUN: begin
        if (s_lvl != ref_q) begin
          evt_s = 1'b1;
          ref_d = s_lvl;
        end else begin
          evt_s = 1'b0;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    if (evt_s) begin
      total_d     = total_q + CNT_ONE;
      evt_pulse_d = 1'b1;
    end else begin
      total_d = total_q;
    end

    // A simultaneous event and drain cancel; a lost event sets the sticky flag.
    if (evt_s && !drain_s) begin
      if (pend_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + CNT_ONE;
      end
    end else if (drain_s && !evt_s) begin
      pend_d = pend_q - CNT_ONE;
    end else begin
      pend_d = pend_q;
    end

    if (clr) begin
      state_d     = INIT;
      settle_d    = 3'd0;
      pend_d      = CNT_ZERO;
      total_d     = CNT_ZERO;
      ovf_d       = 1'b0;
      evt_pulse_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    valid_d = (pend_d != CNT_ZERO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= INIT;
      ref_q       <= 1'b0;
      settle_q    <= SETTLE_RST;
      evt_pulse_q <= 1'b0;
      valid_q     <= 1'b0;
      pend_q      <= CNT_ZERO;
      total_q     <= CNT_ZERO;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      settle_q    <= settle_d;
      evt_pulse_q <= evt_pulse_d;
      valid_q     <= valid_d;
      pend_q      <= pend_d;
      total_q     <= total_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign out_valid = valid_q;
  assign pend_cnt  = pend_q;
  assign total_cnt = total_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx: directed scenarios plus a randomized
// phase, checked against an event-count reference model.
module tb_toggle_event_rx;

  localparam int S = 2;
  localparam int W = 4;
  localparam int MAXC = (1 << W) - 1;
  localparam int SCHED_N = 8192;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         tog_in = 1'b1;
  logic         clr = 1'b0;
  logic         out_ready = 1'b0;
  logic         evt_pulse;
  logic         out_valid;
  logic [W-1:0] pend_cnt;
  logic [W-1:0] total_cnt;
  logic         ovf;

  always #5 clk = ~clk;

  toggle_event_rx #(
    .SYNC_STAGES(S),
    .CNT_W      (W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tog_in   (tog_in),
    .clr      (clr),
    .out_ready(out_ready),
    .evt_pulse(evt_pulse),
    .out_valid(out_valid),
    .pend_cnt (pend_cnt),
    .total_cnt(total_cnt),
    .ovf      (ovf)
  );

  typedef struct {
    int total;
    int pend;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   ev_sched [SCHED_N];
  int   m_pend = 0;
  int   m_total = 0;
  bit   m_ovf = 1'b0;
  int   m_init_left = S + 1;
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an event lands SYNC_STAGES edges after the toggle is
  // first sampled, unless the receiver is (re)capturing its reference level.
  always @(posedge clk or negedge rstn) begin
    automatic int e = cyc + 1;
    automatic int p = m_pend;
    automatic int t = m_total;
    automatic bit o = m_ovf;
    automatic bit ev = 1'b0;
    automatic bit dr = 1'b0;
    if (!rstn) begin
      m_pend      <= 0;
      m_total     <= 0;
      m_ovf       <= 1'b0;
      m_init_left <= S + 1;
      sb_q.delete();
    end else begin
      if (clr) begin
        p = 0;
        t = 0;
        o = 1'b0;
        m_init_left <= 1;
      end else begin
        if (m_init_left > 0) m_init_left <= m_init_left - 1;
        else if (e < SCHED_N) ev = ev_sched[e];
        dr = (p != 0) && out_ready;
        if (ev) t = (t + 1) % (MAXC + 1);
        if (ev && !dr) begin
          if (p == MAXC) o = 1'b1;
          else p = p + 1;
        end else if (dr && !ev) begin
          p = p - 1;
        end
        if (ev) sb_q.push_back('{total: t, pend: p});
      end
      m_pend  <= p;
      m_total <= t;
      m_ovf   <= o;
    end
  end

  // Monitor: every pulse must match a queued expectation; counters are
  // compared against the model every cycle.
  always @(negedge clk) begin
    if (evt_pulse) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", evt_pulse, 0);
      end else begin
        automatic exp_t x = sb_q.pop_front();
        check("pulse_total", total_cnt, x.total);
        check("pulse_pend", pend_cnt, x.pend);
      end
    end else if (sb_q.size() != 0) begin
      check("missing_pulse", evt_pulse, 1);
      sb_q.delete();
    end
    check("pend_cnt", pend_cnt, m_pend);
    check("out_valid", out_valid, (m_pend != 0) ? 1 : 0);
    check("total_cnt", total_cnt, m_total);
    check("ovf", ovf, m_ovf);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    tog_in = ~tog_in;
    if (cyc + 1 + S < SCHED_N) ev_sched[cyc + 1 + S] = 1'b1;
  endtask

  initial begin
    // Reset with tog_in already high: no event may be seen.
    tick(3);
    rstn = 1'b1;
    tick(12);
    check("held1_pend", pend_cnt, 0);
    check("held1_valid", out_valid, 0);

    // Five spaced toggles, no draining.
    for (int i = 0; i < 5; i++) begin
      toggle();
      tick(4);
    end
    tick(2);
    check("five_pend", pend_cnt, 5);
    check("five_total", total_cnt, 5);

    // Drain to 3, then event and drain on the same edge.
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    tick(2);
    check("drain_pend", pend_cnt, 3);
    toggle();
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(3);
    check("same_edge_pend", pend_cnt, 3);
    check("same_edge_total", total_cnt, 6);

    // Clear, then 17 toggles for saturation and total wrap.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    check("clr_total", total_cnt, 0);
    for (int i = 0; i < 17; i++) begin
      toggle();
      tick(4);
    end
    tick(2);
    check("sat_pend", pend_cnt, 15);
    check("sat_ovf", ovf, 1);
    check("sat_total", total_cnt, 1);

    // Drain to 6, then clear on the edge of a detected toggle.
    out_ready = 1'b1;
    tick(9);
    out_ready = 1'b0;
    tick(2);
    check("pre_clr_pend", pend_cnt, 6);
    toggle();
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);
    check("clr_evt_pend", pend_cnt, 0);
    check("clr_evt_ovf", ovf, 0);
    check("clr_evt_total", total_cnt, 0);
    toggle();
    tick(5);
    check("after_clr_pend", pend_cnt, 1);

    // Build pend=4, then asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      toggle();
      tick(4);
    end
    tick(2);
    check("pre_rst_pend", pend_cnt, 4);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_pend", pend_cnt, 0);
    check("rst_valid", out_valid, 0);
    check("rst_total", total_cnt, 0);
    check("rst_pulse", evt_pulse, 0);
    tick(3);
    rstn = 1'b1;
    tick(6);
    toggle();
    tick(5);
    check("post_rst_pend", pend_cnt, 1);
    check("post_rst_total", total_cnt, 1);

    // Randomized toggles, draining and occasional clears.
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) toggle();
      tick(1);
    end
    clr = 1'b0;
    out_ready = 1'b0;
    tick(8);
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
